// File: rtl/alu_booth_mul_if.sv
// ============================================================================
// Module      : alu_booth_mul_if
// Description : Start/busy/done handshake and operand/result bus for the
//               ALU Booth multiplier. Optional ovf when ALU_MUL_OVF_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_booth_mul_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
`ifdef ALU_MUL_OVF_EN
  logic                 ovf;

  modport master (output start, a, b, input busy, done, product, ovf);
  modport slave  (input start, a, b, output busy, done, product, ovf);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

`default_nettype wire

// File: rtl/alu_booth_mul.sv
// ============================================================================
// Module      : alu_booth_mul
// Description : Iterative radix-2 Booth signed multiplier, WIDTH cycles per
//               product. Define ALU_MUL_OVF_EN to add the registered ovf flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_booth_mul #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_booth_mul_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [WIDTH:0]     r_m;
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_1;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_m_neg;
  logic [WIDTH:0]     w_t;
  logic [WIDTH:0]     w_a_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_busy;
  logic               w_done;

  // A new operation is accepted from IDLE or directly out of DONE.
  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_cnt == CW'(1));

  // Two's-complement negation of the multiplicand, as the ALU negate stage does.
  assign w_m_neg = ~r_m + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_t = r_a;
    case ({r_q[0], r_q_1})
      2'b01:   w_t = r_a + r_m;
      2'b10:   w_t = r_a + w_m_neg;
      default: w_t = r_a;
    endcase
  end

  assign w_a_nxt    = {w_t[WIDTH], w_t[WIDTH:1]};
  assign w_q_nxt    = {w_t[0], r_q[WIDTH-1:1]};
  assign w_prod_nxt = {w_a_nxt[WIDTH-1:0], w_q_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.product = r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_q_1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_m   <= {bus.a[WIDTH-1], bus.a};
      r_a   <= '0;
      r_q   <= bus.b;
      r_q_1 <= 1'b0;
      r_cnt <= CW'(WIDTH);
    end else if (r_state == S_RUN) begin
      r_a   <= w_a_nxt;
      r_q   <= w_q_nxt;
      r_q_1 <= r_q[0];
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_product <= w_prod_nxt;
      end
    end
  end

`ifdef ALU_MUL_OVF_EN
  logic               r_ovf;
  logic [WIDTH:0]     w_hi;

  // Representable in WIDTH bits only if the top WIDTH+1 bits are all-equal.
  assign w_hi = w_prod_nxt[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && r_state == S_RUN && w_last) begin
      r_ovf <= !((&w_hi) || !(|w_hi));
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_booth_mul.sv
// ============================================================================
// Module      : tb_alu_booth_mul
// Description : Randomized self-checking bench for alu_booth_mul against a
//               plain-arithmetic signed multiply model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_booth_mul;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] prev_product;

  alu_booth_mul_if #(.WIDTH(WIDTH)) bus ();

  alu_booth_mul #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  function automatic logic ovf_ref(input logic [63:0] p);
    logic [31:0] lo;
    lo = p[31:0];
    return (longint'(p) != longint'($signed(lo)));
  endfunction

  // Drive start with operands for one edge (edge 0), then scramble operands.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Samples at negedges after edge 0; returns at the done cycle or on timeout.
  task automatic wait_done(input int repulse_at, output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.start) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (cyc == 5) chk("hold_prev", bus.product, prev_product);
      if (cyc == repulse_at) begin
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
      end
    end while (!bus.done && cyc < 100);
  endtask

  task automatic check_result(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                              input int cyc, input int busy_cnt);
    logic [63:0] exp;
    exp = mul_ref(ta, tb_v);
    chk({tag, "_latency"}, 64'(cyc), 64'd33);
    chk({tag, "_busy"}, 64'(busy_cnt), 64'd32);
    chk({tag, "_product"}, bus.product, exp);
`ifdef ALU_MUL_OVF_EN
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'(ovf_ref(exp)));
`endif
    prev_product = exp;
  endtask

  task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb_v);
    int cyc;
    int bc;
    start_op(ta, tb_v);
    wait_done(-1, cyc, bc);
    check_result(tag, ta, tb_v, cyc, bc);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_held"}, bus.product, prev_product);
  endtask

  initial begin
    int cyc;
    int bc;
    int done_seen;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    prev_product = '0;

    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("basic", 32'd3, 32'hFFFF_FFFB);
    run_one("minmin", 32'h8000_0000, 32'h8000_0000);
    run_one("m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_one("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_one("zero", 32'd0, 32'h1234_5678);
    run_one("minmax", 32'h8000_0000, 32'h7FFF_FFFF);

    // Start re-pulse during RUN is ignored; start held in DONE chains a new run.
    start_op(32'd3, 32'hFFFF_FFFB);
    wait_done(10, cyc, bc);
    check_result("repulse", 32'd3, 32'hFFFF_FFFB, cyc, bc);
    bus.start = 1'b1;
    bus.a     = 32'd2;
    bus.b     = 32'hFFFF_FFFD;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    wait_done(-1, cyc, bc);
    check_result("chain", 32'd2, 32'hFFFF_FFFD, cyc, bc);

    // Asynchronous reset between edges during RUN.
    start_op(32'd5, 32'd6);
    for (int i = 0; i < 15; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_product", bus.product, 64'd0);
    prev_product = '0;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("arst_idle", 64'(done_seen), 64'd0);
    run_one("after_rst", 32'd5, 32'd6);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 1) ra = {1'b1, 31'(0)} | (ra & 32'hF);
      if (i % 5 == 2) rb = ~rb[31] ? 32'hFFFF_FFFF : rb;
      run_one("rand", ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
